// File: rtl/irq_ctrl_pkg.sv
// Shared encodings for the interrupt controller: FSM states, config selects
// and the channel-id width helper.
package irq_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [1:0] CFG_MASK = 2'd0;
    localparam logic [1:0] CFG_MODE = 2'd1;
    localparam logic [1:0] CFG_CLR  = 2'd2;

    // Bits needed to index n channels (minimum 1).
    function automatic int id_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Multi-bit, multi-stage pin synchroniser with async active-low reset.
module irq_sync #(
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int s = 0; s < STAGES; s++) stage[s] <= '0;
        end else begin
            stage[0] <= d;
            for (int s = 1; s < STAGES; s++) stage[s] <= stage[s-1];
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/irq_ctrl.sv
// N-channel interrupt controller: synchronised pins, level/edge pending,
// masking, fixed lowest-index priority and a req/ack/eoi core handshake.
//
// state   | meaning
// IDLE    | no request; arbitrate the eligible vector
// REQ     | o_int_req high, o_int_id frozen, waiting for ack or withdrawal
// SERVICE | handler running, no new request until eoi
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_IRQ       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = 3
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_sel,
    input  logic [N_IRQ-1:0] i_cfg_wdata,
    output logic [N_IRQ-1:0] o_mask,
    output logic [N_IRQ-1:0] o_mode,
    output logic [N_IRQ-1:0] o_pending,
    output logic             o_int_req,
    output logic [ID_W-1:0]  o_int_id,
    input  logic             i_int_ack,
    input  logic             i_eoi,
    output logic             o_in_service
);

    logic [N_IRQ-1:0] s_irq;
    logic [N_IRQ-1:0] s_prev;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] mode;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] pending_nxt;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] ack_vec;
    logic [N_IRQ-1:0] to_edge;
    logic [1:0]       state;
    logic [ID_W-1:0]  int_id;
    logic [ID_W-1:0]  winner;
    logic             mask_we;
    logic             mode_we;
    logic             clr_we;
    logic             ack_fire;

    irq_sync #(
        .W      (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .n_rst (n_rst),
        .d     (i_irq),
        .q     (s_irq)
    );

    assign mask_we  = i_cfg_we && (i_cfg_sel == CFG_MASK);
    assign mode_we  = i_cfg_we && (i_cfg_sel == CFG_MODE);
    assign clr_we   = i_cfg_we && (i_cfg_sel == CFG_CLR);
    assign ack_fire = (state == ST_REQ) && i_int_ack;

    assign rise    = s_irq & ~s_prev;
    assign ack_vec = ack_fire ? ({{(N_IRQ-1){1'b0}}, 1'b1} << int_id) : '0;
    assign clr     = (clr_we ? i_cfg_wdata : '0) | ack_vec;
    assign to_edge = mode_we ? (i_cfg_wdata & ~mode) : '0;

    // Edge channels: a rise in the same cycle as a clear keeps the bit set.
    // Channels switching to edge start clean; s_prev already tracks s_irq.
    assign pending_nxt = ~to_edge & ((mode & (rise | (pending & ~clr))) |
                                     (~mode & s_irq));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mask    <= '1;
            mode    <= '0;
            pending <= '0;
            s_prev  <= '0;
        end else begin
            s_prev  <= s_irq;
            pending <= pending_nxt;
            if (mask_we) mask <= i_cfg_wdata;
            if (mode_we) mode <= i_cfg_wdata;
        end
    end

    assign eligible = pending & ~mask;

    always_comb begin
        winner = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state  <= ST_IDLE;
            int_id <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|eligible) begin
                        int_id <= winner;
                        state  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_int_ack)               state <= ST_SERVICE;
                    else if (!eligible[int_id])  state <= ST_IDLE;
                end
                ST_SERVICE: begin
                    if (i_eoi) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_mask       = mask;
    assign o_mode       = mode;
    assign o_pending    = pending;
    assign o_int_req    = (state == ST_REQ);
    assign o_int_id     = int_id;
    assign o_in_service = (state == ST_SERVICE);

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: latency, priority, freeze, withdrawal,
// set-wins-clear, mask withdrawal and reset during service.
module tb_irq_ctrl;

    localparam int N  = 8;
    localparam int SS = 2;
    localparam int IW = 3;

    logic         clk;
    logic         n_rst;
    logic [N-1:0] i_irq;
    logic         i_cfg_we;
    logic [1:0]   i_cfg_sel;
    logic [N-1:0] i_cfg_wdata;
    logic [N-1:0] o_mask;
    logic [N-1:0] o_mode;
    logic [N-1:0] o_pending;
    logic         o_int_req;
    logic [IW-1:0] o_int_id;
    logic         i_int_ack;
    logic         i_eoi;
    logic         o_in_service;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    irq_ctrl #(
        .N_IRQ       (N),
        .SYNC_STAGES (SS),
        .ID_W        (IW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_irq        (i_irq),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_sel    (i_cfg_sel),
        .i_cfg_wdata  (i_cfg_wdata),
        .o_mask       (o_mask),
        .o_mode       (o_mode),
        .o_pending    (o_pending),
        .o_int_req    (o_int_req),
        .o_int_id     (o_int_id),
        .i_int_ack    (i_int_ack),
        .i_eoi        (i_eoi),
        .o_in_service (o_in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] sel, input logic [N-1:0] data);
        i_cfg_we    = 1'b1;
        i_cfg_sel   = sel;
        i_cfg_wdata = data;
        tick();
        i_cfg_we    = 1'b0;
        i_cfg_wdata = '0;
    endtask

    task automatic ack();
        i_int_ack = 1'b1;
        tick();
        i_int_ack = 1'b0;
    endtask

    task automatic eoi();
        i_eoi = 1'b1;
        tick();
        i_eoi = 1'b0;
    endtask

    initial begin
        n_rst       = 1'b0;
        i_irq       = '0;
        i_cfg_we    = 1'b0;
        i_cfg_sel   = 2'd0;
        i_cfg_wdata = '0;
        i_int_ack   = 1'b0;
        i_eoi       = 1'b0;
        repeat (3) tick();

        chk("rst_mask",    32'(o_mask),       32'hff);
        chk("rst_mode",    32'(o_mode),       32'h00);
        chk("rst_pending", 32'(o_pending),    32'h00);
        chk("rst_req",     32'(o_int_req),    32'h0);
        chk("rst_id",      32'(o_int_id),     32'h0);
        chk("rst_insvc",   32'(o_in_service), 32'h0);
        n_rst = 1'b1;
        tick();

        // ch3 level: request exactly SS+2 edges after the pin is driven
        cfg(2'd0, 8'hf7);
        chk("t1_mask", 32'(o_mask), 32'hf7);
        i_irq[3] = 1'b1;
        for (int i = 1; i <= SS + 1; i++) begin
            tick();
            chk("t1_req_early", 32'(o_int_req), 32'h0);
        end
        chk("t1_pending", 32'(o_pending), 32'h08);
        tick();
        chk("t1_req", 32'(o_int_req), 32'h1);
        chk("t1_id",  32'(o_int_id),  32'h3);
        ack();
        chk("t1_insvc", 32'(o_in_service), 32'h1);
        chk("t1_req_off", 32'(o_int_req), 32'h0);
        i_irq[3] = 1'b0;
        repeat (4) tick();
        chk("t1_pend_drop", 32'(o_pending), 32'h00);
        eoi();
        chk("t1_insvc_off", 32'(o_in_service), 32'h0);
        repeat (2) tick();
        chk("t1_no_rereq", 32'(o_int_req), 32'h0);

        // ack and eoi outside their states are ignored
        ack();
        chk("prot_ack_idle", 32'(o_in_service), 32'h0);
        eoi();
        chk("prot_eoi_idle", 32'(o_int_req), 32'h0);

        // edge ch0 and ch5 rising together: ch0 first
        cfg(2'd1, 8'h21);
        cfg(2'd0, 8'hde);
        i_irq[0] = 1'b1;
        i_irq[5] = 1'b1;
        repeat (SS + 2) tick();
        chk("t2_req",     32'(o_int_req), 32'h1);
        chk("t2_id0",     32'(o_int_id),  32'h0);
        chk("t2_pending", 32'(o_pending), 32'h21);
        ack();
        chk("t2_pend_ack0", 32'(o_pending), 32'h20);
        chk("t2_insvc",     32'(o_in_service), 32'h1);
        eoi();
        chk("t2_eoi_req", 32'(o_int_req), 32'h0);
        tick();
        chk("t2_req5", 32'(o_int_req), 32'h1);
        chk("t2_id5",  32'(o_int_id),  32'h5);
        chk("t2_pend5_hold", 32'(o_pending), 32'h20);
        ack();
        chk("t2_pend_ack5", 32'(o_pending), 32'h00);
        eoi();
        i_irq[0] = 1'b0;
        i_irq[5] = 1'b0;

        // ch2 in REQ, ch1 arrives later: id stays frozen at 2
        cfg(2'd1, 8'h27);
        cfg(2'd0, 8'hf9);
        i_irq[2] = 1'b1;
        repeat (SS + 2) tick();
        chk("t3_id2", 32'(o_int_id), 32'h2);
        i_irq[1] = 1'b1;
        repeat (SS + 2) tick();
        chk("t3_pending", 32'(o_pending), 32'h06);
        chk("t3_frozen",  32'(o_int_id),  32'h2);
        chk("t3_req",     32'(o_int_req), 32'h1);
        ack();
        eoi();
        tick();
        chk("t3_req1", 32'(o_int_req), 32'h1);
        chk("t3_id1",  32'(o_int_id),  32'h1);
        ack();
        eoi();
        i_irq[1] = 1'b0;
        i_irq[2] = 1'b0;

        // ch4 level drops while in REQ: request withdrawn
        cfg(2'd0, 8'hef);
        i_irq[4] = 1'b1;
        repeat (SS + 2) tick();
        chk("t4_req", 32'(o_int_req), 32'h1);
        chk("t4_id4", 32'(o_int_id),  32'h4);
        i_irq[4] = 1'b0;
        repeat (SS + 2) tick();
        chk("t4_withdraw", 32'(o_int_req),    32'h0);
        chk("t4_insvc",    32'(o_in_service), 32'h0);

        // ch6 edge: clear write in the cycle the edge is detected
        cfg(2'd1, 8'h67);
        cfg(2'd0, 8'hbf);
        i_irq[6] = 1'b1;
        repeat (SS) tick();
        cfg(2'd2, 8'h40);
        chk("t5_set_wins", 32'(o_pending[6]), 32'h1);
        tick();
        chk("t5_req", 32'(o_int_req), 32'h1);
        chk("t5_id6", 32'(o_int_id),  32'h6);
        cfg(2'd0, 8'hff);
        tick();
        chk("t5_mask_withdraw", 32'(o_int_req), 32'h0);
        cfg(2'd2, 8'h40);
        chk("t5_clear", 32'(o_pending[6]), 32'h0);

        // reset during SERVICE
        cfg(2'd0, 8'h7f);
        i_irq[7] = 1'b1;
        repeat (SS + 2) tick();
        chk("t6_id7", 32'(o_int_id), 32'h7);
        ack();
        chk("t6_insvc", 32'(o_in_service), 32'h1);
        n_rst = 1'b0;
        #1;
        chk("t6_rst_insvc",   32'(o_in_service), 32'h0);
        chk("t6_rst_req",     32'(o_int_req),    32'h0);
        chk("t6_rst_id",      32'(o_int_id),     32'h0);
        chk("t6_rst_mask",    32'(o_mask),       32'hff);
        chk("t6_rst_mode",    32'(o_mode),       32'h00);
        chk("t6_rst_pending", 32'(o_pending),    32'h00);
        tick();
        n_rst = 1'b1;
        repeat (6) tick();
        chk("t6_post_pending", 32'(o_pending),    32'hc0);
        chk("t6_post_req",     32'(o_int_req),    32'h0);
        chk("t6_post_insvc",   32'(o_in_service), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
